instr_stream_loader: RTL and testbench
======================================

# instr_stream_loader

Sequences the loading of the instruction memory controller from a byte-serial source (host/UART/DMA). Packs incoming instruction bytes into write windows, issues one write request per window with the matching pointer shift, and holds off the source when the circular instruction buffer lacks space. It tracks buffer occupancy from the fetch side's read-pointer shifts, so write and read traffic share the buffer without overrun.

## Interface
- WIN, 8: write window size in bytes (power of two, ≥2)
- LOG_WIN, 3: log2(WIN)
- LOG_RWIN, 3: width of the read-shift field
- DEPTH, 256: instruction buffer depth in bytes (power of two)
- LVL_W, 9: occupancy width, log2(DEPTH)+1
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_byte  in  8  instruction byte from source
- s_vld  in  1  s_byte valid
- s_last  in  1  marks final byte of the program, qualified by s_vld
- s_rdy  out  1  loader accepts s_byte this cycle (s_vld & s_rdy)
- we  out  1  write request to instruction memory, one-cycle pulse
- write_pointer_shift_minusone  out  LOG_WIN  bytes in window minus one, valid with we
- wr_data  out  WIN*8  packed window, byte k at [8k+:8]; unfilled bytes zero
- rd_shift_vld  in  1  fetch side consumed bytes this cycle
- rd_shift_minusone  in  LOG_RWIN  bytes consumed minus one
- level  out  LVL_W  bytes written but not yet consumed
- load_done  out  1  sticky; last window written
- overflow_err  out  1  sticky; a read shift exceeded level

## Operation
- States: FILL, WAIT_SPACE, ISSUE, DONE.
- FILL: s_rdy=1. Each accepted byte goes to slot cnt; cnt increments. If cnt reaches WIN or the byte has s_last, latch last_seen and go to WAIT_SPACE.
- WAIT_SPACE: s_rdy=0. If DEPTH − level ≥ cnt, go to ISSUE; otherwise stay.
- ISSUE: we=1 for exactly one cycle, write_pointer_shift_minusone=cnt−1, wr_data=packed window. level += cnt. Clear the window register and cnt. Next state is DONE if last_seen, else FILL.
- DONE: s_rdy=0; load_done=1. Exit only through reset.
- Occupancy: each cycle level ← level + (we ? cnt : 0) − (rd_shift_vld ? rd_shift_minusone+1 : 0). Both terms apply in the same cycle when simultaneous.
- If the consumed amount exceeds level: set overflow_err, clamp level to 0.
- Byte counts are unsigned LVL_W wide. Level never exceeds DEPTH.
- wr_data holds its value until the next ISSUE; this block asserts only we.

## Timing
- Reset values: s_rdy=0 during reset and 1 from the first cycle after release (state FILL). we=0, write_pointer_shift_minusone=0, wr_data=0, level=0, load_done=0, overflow_err=0, cnt=0.
- Latency from the accepted byte that completes a window to we: 2 cycles with sufficient space (WAIT_SPACE 1 cycle, then ISSUE). Longer when stalled for space.
- Consecutive windows: WIN+2 cycles each, with the source streaming every cycle.
- The space check in WAIT_SPACE uses the registered level. A read shift in the same cycle frees space visible from the next cycle.
- s_last on the first byte of a window gives a single-byte write (minusone=0).
- s_last ignored without s_vld&s_rdy. Bytes offered in WAIT_SPACE/ISSUE/DONE are not accepted.
- Reset mid-operation discards the partial window and all occupancy; no we pulse is emitted.

## Test plan
- Stream 16 bytes 0x00..0x0F, s_last on 0x0F, no reads. Two we pulses: minusone=7, wr_data=0x0706050403020100 then 0x0F0E0D0C0B0A0908. level=16, load_done=1 after the second pulse.
- 3 bytes 0xAA,0xBB,0xCC with s_last on 0xCC. Single we: minusone=2, wr_data=0x0000000000CCBBAA.
- Fill to level=252 without reads, then complete a full window. Stays in WAIT_SPACE, s_rdy=0. Pulse rd_shift_vld with minusone=3: we fires 2 cycles later, level=256.
- Same cycle: we with 8 bytes and rd_shift_vld with minusone=4. level increases by exactly 3.
- At level=2, rd_shift_vld with minusone=5 → overflow_err=1, level=0.
- Assert rst_n low after 5 bytes accepted. All outputs return to reset values, and no we occurs. The next 8 bytes form a fresh window starting at byte 0.

Source files
------------

// File: rtl/instr_stream_loader.sv
// Packs a byte-serial instruction stream into WIN-byte write windows for the instruction buffer.
// Issues one write per window once the circular buffer has room, and tracks occupancy against fetch-side reads.
module instr_stream_loader #(
  parameter int WIN      = 8,
  parameter int LOG_WIN  = 3,
  parameter int LOG_RWIN = 3,
  parameter int DEPTH    = 256,
  parameter int LVL_W    = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_byte,
  input  logic                 s_vld,
  input  logic                 s_last,
  output logic                 s_rdy,
  output logic                 we,
  output logic [LOG_WIN-1:0]   write_pointer_shift_minusone,
  output logic [WIN*8-1:0]     wr_data,
  input  logic                 rd_shift_vld,
  input  logic [LOG_RWIN-1:0]  rd_shift_minusone,
  output logic [LVL_W-1:0]     level,
  output logic                 load_done,
  output logic                 overflow_err
);

  typedef enum logic [1:0] {FILL, WAIT_SPACE, ISSUE, DONE} state_t;
  typedef logic [LOG_WIN:0] cnt_t;
  typedef logic [LVL_W:0]   sum_t;

  localparam sum_t DEPTH_S = sum_t'(DEPTH);

  state_t             state_q;
  cnt_t               cnt_q;
  logic [WIN*8-1:0]   win_q;
  logic               last_seen_q;
  logic               s_rdy_q;
  logic               we_q;
  logic [LOG_WIN-1:0] minus_q;
  logic [WIN*8-1:0]   wr_data_q;
  logic [LVL_W-1:0]   level_q;
  logic               load_done_q;
  logic               ovf_q;

  logic               accept;
  cnt_t               cnt_inc;
  logic               close_win;
  logic               space_ok;
  sum_t               added;
  sum_t               consumed;
  sum_t               total;
  logic               underflow;
  logic [LVL_W-1:0]   level_d;

  always_comb begin
    accept    = (state_q == FILL) && s_rdy_q && s_vld;
    cnt_inc   = cnt_q + cnt_t'(1);
    close_win = accept && ((cnt_inc == cnt_t'(WIN)) || s_last);
    space_ok  = (DEPTH_S - sum_t'(level_q)) >= sum_t'(cnt_q);
    // Writes and reads in the same cycle net out before the underflow test.
    added     = (state_q == ISSUE) ? sum_t'(cnt_q) : '0;
    consumed  = rd_shift_vld ? (sum_t'(rd_shift_minusone) + sum_t'(1)) : '0;
    total     = sum_t'(level_q) + added;
    underflow = consumed > total;
    level_d   = underflow ? '0 : LVL_W'(total - consumed);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      win_q       <= '0;
      last_seen_q <= 1'b0;
      s_rdy_q     <= 1'b0;
      we_q        <= 1'b0;
      minus_q     <= '0;
      wr_data_q   <= '0;
      level_q     <= '0;
      load_done_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      level_q <= level_d;
      if (underflow) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        FILL: begin
          s_rdy_q <= !close_win;
          if (accept) begin
            for (int k = 0; k < WIN; k++) begin
              if (cnt_q[LOG_WIN-1:0] == LOG_WIN'(k)) begin
                win_q[8*k +: 8] <= s_byte;
              end
            end
            cnt_q <= cnt_inc;
          end
          if (close_win) begin
            last_seen_q <= s_last;
            state_q     <= WAIT_SPACE;
          end
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            state_q   <= ISSUE;
            we_q      <= 1'b1;
            minus_q   <= LOG_WIN'(cnt_q - cnt_t'(1));
            wr_data_q <= win_q;
          end
        end
        ISSUE: begin
          we_q  <= 1'b0;
          win_q <= '0;
          cnt_q <= '0;
          if (last_seen_q) begin
            state_q     <= DONE;
            load_done_q <= 1'b1;
          end else begin
            state_q <= FILL;
            s_rdy_q <= 1'b1;
          end
        end
        default: begin
          s_rdy_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_rdy                        = s_rdy_q;
  assign we                           = we_q;
  assign write_pointer_shift_minusone = minus_q;
  assign wr_data                      = wr_data_q;
  assign level                        = level_q;
  assign load_done                    = load_done_q;
  assign overflow_err                 = ovf_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomized and directed bench for instr_stream_loader against a queue-based window/occupancy model.
module tb_instr_stream_loader;
  localparam int WIN = 8, LOG_WIN = 3, LOG_RWIN = 3, DEPTH = 256, LVL_W = 9;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          s_byte = '0;
  logic                s_vld = 1'b0;
  logic                s_last = 1'b0;
  logic                s_rdy;
  logic                we;
  logic [LOG_WIN-1:0]  wp_m1;
  logic [WIN*8-1:0]    wr_data;
  logic                rd_vld = 1'b0;
  logic [LOG_RWIN-1:0] rd_m1 = '0;
  logic [LVL_W-1:0]    level;
  logic                load_done;
  logic                overflow_err;

  instr_stream_loader #(.WIN(WIN), .LOG_WIN(LOG_WIN), .LOG_RWIN(LOG_RWIN), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_byte(s_byte), .s_vld(s_vld), .s_last(s_last), .s_rdy(s_rdy),
    .we(we), .write_pointer_shift_minusone(wp_m1), .wr_data(wr_data),
    .rd_shift_vld(rd_vld), .rd_shift_minusone(rd_m1), .level(level),
    .load_done(load_done), .overflow_err(overflow_err));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a byte queue for the open window plus a few flags describing where it is in its life.
  bit              m_rdy, m_we, m_done, m_ovf, m_closed, m_last;
  int              m_level;
  logic [2:0]      m_minus;
  logic [63:0]     m_data;
  byte unsigned    m_buf[$];
  logic [63:0]     wr_log[$];

  always @(posedge clk or negedge rst_n) begin
    int add, cons, tot, lvl_old;
    bit we_old;
    if (!rst_n) begin
      m_rdy = 0; m_we = 0; m_done = 0; m_ovf = 0; m_closed = 0; m_last = 0;
      m_level = 0; m_minus = '0; m_data = '0; m_buf.delete();
    end else begin
      we_old  = m_we;
      lvl_old = m_level;
      add  = m_we ? int'(m_minus) + 1 : 0;
      cons = rd_vld ? int'(rd_m1) + 1 : 0;
      tot  = m_level + add;
      if (cons > tot) begin m_ovf = 1; m_level = 0; end
      else m_level = tot - cons;
      if (we_old) begin
        m_we = 0;
        if (m_last) m_done = 1; else m_rdy = 1;
      end else if (m_done) begin
        m_rdy = 0;
      end else if (m_closed) begin
        if (DEPTH - lvl_old >= m_buf.size()) begin
          m_we = 1;
          m_minus = 3'(m_buf.size() - 1);
          m_data = '0;
          for (int k = 0; k < m_buf.size(); k++) m_data[8*k +: 8] = m_buf[k];
          m_buf.delete();
          m_closed = 0;
        end
      end else begin
        if (m_rdy && s_vld) begin
          m_buf.push_back(s_byte);
          if (m_buf.size() == WIN || s_last) begin m_closed = 1; m_last = s_last; end
        end
        m_rdy = !m_closed;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("s_rdy", 64'(s_rdy), 64'(m_rdy));
    chk("we", 64'(we), 64'(m_we));
    chk("minusone", 64'(wp_m1), 64'(m_minus));
    chk("wr_data", wr_data, m_data);
    chk("level", 64'(level), 64'(m_level));
    chk("load_done", 64'(load_done), 64'(m_done));
    chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
  end

  always @(negedge clk) if (we === 1'b1) wr_log.push_back(wr_data);

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic timeout(input string name);
    n_cmp++; n_bad++;
    $display("FAIL timeout %s: got no progress, expected completion at %0t", name, $time);
  endtask

  task automatic chk_reset_vals();
    chk("rst s_rdy", 64'(s_rdy), 64'h0);
    chk("rst we", 64'(we), 64'h0);
    chk("rst minusone", 64'(wp_m1), 64'h0);
    chk("rst wr_data", wr_data, 64'h0);
    chk("rst level", 64'(level), 64'h0);
    chk("rst load_done", 64'(load_done), 64'h0);
    chk("rst overflow", 64'(overflow_err), 64'h0);
  endtask

  task automatic do_reset(input bit check);
    s_vld = 0; s_last = 0; rd_vld = 0;
    rst_n = 0;
    #1;
    if (check) chk_reset_vals();
    step(); step();
    rst_n = 1;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int t;
    s_vld = 1; s_byte = b; s_last = last;
    t = 0;
    while (!m_rdy && t < 300) begin step(); t++; end
    if (t >= 300) timeout("send_byte");
    step();
    s_vld = 0; s_last = 0;
  endtask

  task automatic read_shift(input logic [2:0] m1);
    rd_vld = 1; rd_m1 = m1;
    step();
    rd_vld = 0;
  endtask

  task automatic wait_model(input int which, input int limit);
    int t;
    t = 0;
    while (t < limit && !((which == 0 && m_done) || (which == 1 && m_we) || (which == 2 && m_level == 256))) begin
      step(); t++;
    end
    if (t >= limit) timeout("wait_model");
  endtask

  initial begin
    int base;
    // Two full windows, the second ending the program.
    do_reset(1);
    base = wr_log.size();
    for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
    wait_model(0, 20);
    chk("t1 we count", 64'(wr_log.size() - base), 64'd2);
    if (wr_log.size() >= base + 2) begin
      chk("t1 window0", wr_log[base], 64'h0706050403020100);
      chk("t1 window1", wr_log[base+1], 64'h0F0E0D0C0B0A0908);
    end
    chk("t1 minusone", 64'(wp_m1), 64'd7);
    chk("t1 level", 64'(level), 64'd16);
    chk("t1 load_done", 64'(load_done), 64'd1);

    // Short final window.
    do_reset(0);
    base = wr_log.size();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
    wait_model(0, 20);
    chk("t2 we count", 64'(wr_log.size() - base), 64'd1);
    if (wr_log.size() > base) chk("t2 window", wr_log[base], 64'h0000000000CCBBAA);
    chk("t2 minusone", 64'(wp_m1), 64'd2);

    // Full buffer, then a stalled window released by reads.
    do_reset(0);
    for (int i = 0; i < 256; i++) send_byte(8'($urandom), 0);
    wait_model(2, 20);
    step();
    chk("t3 level full", 64'(level), 64'd256);
    read_shift(3'd3);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    repeat (4) step();
    chk("t3 stalled s_rdy", 64'(s_rdy), 64'd0);
    chk("t3 stalled level", 64'(level), 64'd252);
    chk("t3 stalled we", 64'(we), 64'd0);
    read_shift(3'd3);
    @(negedge clk);
    chk("t3 we +1", 64'(we), 64'd0);
    @(negedge clk);
    chk("t3 we +2", 64'(we), 64'd1);
    chk("t3 level at issue", 64'(level), 64'd248);
    step();
    chk("t3 level after", 64'(level), 64'd256);

    // Simultaneous write of 8 and read of 5, then underflow.
    do_reset(0);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 32), 0);
    wait_model(1, 10);
    read_shift(3'd4);
    chk("t4 level", 64'(level), 64'd3);
    read_shift(3'd0);
    chk("t5 level", 64'(level), 64'd2);
    chk("t5 ovf before", 64'(overflow_err), 64'd0);
    read_shift(3'd5);
    chk("t5 ovf", 64'(overflow_err), 64'd1);
    chk("t5 level", 64'(level), 64'd0);

    // Reset mid-window discards the partial window.
    do_reset(0);
    base = wr_log.size();
    for (int i = 0; i < 5; i++) send_byte(8'(i + 64), 0);
    do_reset(1);
    chk("t6 no we", 64'(wr_log.size() - base), 64'd0);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 16), 0);
    repeat (3) step();
    chk("t6 we count", 64'(wr_log.size() - base), 64'd1);
    if (wr_log.size() > base) chk("t6 window", wr_log[base], 64'h1716151413121110);

    // Random traffic.
    for (int ep = 0; ep < 6; ep++) begin
      do_reset(0);
      for (int c = 0; c < 1500; c++) begin
        s_vld  = ($urandom_range(0, 3) != 0);
        s_byte = 8'($urandom);
        s_last = ($urandom_range(0, 599) == 0);
        case (ep % 3)
          0: rd_vld = ($urandom_range(0, 7) == 0);
          1: rd_vld = ($urandom_range(0, 1) == 0);
          default: rd_vld = ($urandom_range(0, 19) == 0);
        endcase
        rd_m1 = 3'($urandom_range(0, 7));
        step();
      end
      s_vld = 0; s_last = 0; rd_vld = 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
